// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one op per start, fixed XLEN+2 cycle
// latency, shift-add multiply and restoring divide on operand magnitudes.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] D,
    output logic [4:0]      A_D,
    output logic            write_enable
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_hi_q, acc_hi_d;   // product high half / remainder
    logic [XLEN-1:0]   acc_lo_q, acc_lo_d;   // multiplier+product low / dividend+quotient
    logic [XLEN-1:0]   b_mag_q, b_mag_d;     // multiplicand / divisor magnitude
    logic [XLEN-1:0]   a_orig_q, a_orig_d;   // original dividend for REM by zero
    logic [2:0]        f_q, f_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;
    logic              dz_q, dz_d;

    logic              busy_d, done_d, we_d;
    logic [XLEN-1:0]   res_d;
    logic [4:0]        ad_d;

    logic              signed_a, signed_b, sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN+1:0]   div_diff;
    logic [PW-1:0]     prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    // State, datapath and output registers
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_hi_q     <= '0;
            acc_lo_q     <= '0;
            b_mag_q      <= '0;
            a_orig_q     <= '0;
            f_q          <= '0;
            rd_q         <= '0;
            neg_q        <= 1'b0;
            dz_q         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            write_enable <= 1'b0;
            D            <= '0;
            A_D          <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_hi_q     <= acc_hi_d;
            acc_lo_q     <= acc_lo_d;
            b_mag_q      <= b_mag_d;
            a_orig_q     <= a_orig_d;
            f_q          <= f_d;
            rd_q         <= rd_d;
            neg_q        <= neg_d;
            dz_q         <= dz_d;
            busy         <= busy_d;
            done         <= done_d;
            write_enable <= we_d;
            D            <= res_d;
            A_D          <= ad_d;
        end
    end

    // Next-state, iteration step and result selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        b_mag_d  = b_mag_q;
        a_orig_d = a_orig_q;
        f_d      = f_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        we_d     = 1'b0;
        res_d    = D;
        ad_d     = A_D;

        // MUL, MULH, MULHSU, DIV, REM treat op_a as signed; MULHSU keeps op_b unsigned
        signed_a = (!funct3[2] && (funct3[1:0] != 2'b11)) || (funct3[2] && !funct3[0]);
        signed_b = (!funct3[2] && !funct3[1]) || (funct3[2] && !funct3[0]);
        sa       = signed_a && op_a[XLEN-1];
        sb       = signed_b && op_b[XLEN-1];
        a_mag    = sa ? XLEN'(0) - op_a : op_a;
        b_mag    = sb ? XLEN'(0) - op_b : op_b;

        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_mag_q} : (XLEN+1)'(0));
        div_sh   = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff = {1'b0, div_sh} - {2'b00, b_mag_q};

        prod     = {acc_hi_q, acc_lo_q};
        prod_s   = neg_q ? PW'(0) - prod : prod;
        quo_s    = neg_q ? XLEN'(0) - acc_lo_q : acc_lo_q;
        rem_s    = neg_q ? XLEN'(0) - acc_hi_q : acc_hi_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    f_d      = funct3;
                    rd_d     = rd_in;
                    acc_hi_d = '0;
                    acc_lo_d = a_mag;
                    b_mag_d  = b_mag;
                    a_orig_d = op_a;
                    neg_d    = (funct3 == 3'b110) ? sa : (sa ^ sb);
                    dz_d     = (op_b == '0);
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (f_q[2]) begin
                    acc_lo_d = {acc_lo_q[XLEN-2:0], ~div_diff[XLEN+1]};
                    acc_hi_d = div_diff[XLEN+1] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
                end else begin
                    acc_hi_d = mul_sum[XLEN:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                case (f_q)
                    3'b000:                 res_d = prod_s[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: res_d = prod_s[PW-1:XLEN];
                    3'b100, 3'b101:         res_d = dz_q ? '1 : quo_s;
                    default:                res_d = dz_q ? a_orig_q : rem_s;
                endcase
                ad_d    = rd_q;
                done_d  = 1'b1;
                we_d    = (rd_q != 5'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule
